// File: rtl/sdram_port_arbiter_pkg.sv
// Shared command codes, address field widths and address packing for the
// SDRAM command-port arbiter.
package sdram_port_arbiter_pkg;

   localparam int PAGE_W = 3;
   localparam int ROW_W  = 9;
   localparam int COL_W  = 10;
   localparam int ADDR_W = PAGE_W + ROW_W + COL_W;
   localparam int DATA_W = 16;
   localparam int OP_W   = 2;

   localparam logic [OP_W-1:0] CMD_NONE  = 2'b00;
   localparam logic [OP_W-1:0] CMD_READ  = 2'b01;
   localparam logic [OP_W-1:0] CMD_WRITE = 2'b10;
   localparam logic [OP_W-1:0] CMD_REF   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2
   } arb_state_t;

   function automatic logic [ADDR_W-1:0] pack_addr(
      input logic [PAGE_W-1:0] page,
      input logic [ROW_W-1:0]  row,
      input logic [COL_W-1:0]  col
   );
      return {page, row, col};
   endfunction

endpackage

// File: rtl/sdram_port_arbiter.sv
// Arbitrates refresh, TFT line-fetch reads and user pixel writes onto the single
// SDRAM controller command port, one outstanding command at a time.
module sdram_port_arbiter
   import sdram_port_arbiter_pkg::*;
#(
   parameter int RD_LEN     = 800,
   parameter int STARVE_MAX = 4,
   parameter int LEN_W      = 10
) (
   input  logic              clk,
   input  logic              sclr,
   input  logic              ref_req,
   output logic              ref_ack,
   input  logic              rd_req,
   input  logic [PAGE_W-1:0] rd_page,
   input  logic [ROW_W-1:0]  rd_row,
   output logic              rd_ack,
   output logic              rd_done,
   input  logic              wr_full,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [PAGE_W-1:0] wr_page,
   input  logic [ROW_W-1:0]  wr_row,
   input  logic [COL_W-1:0]  wr_col,
   output logic              wr_ack,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [OP_W-1:0]   cmd_op,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [LEN_W-1:0]  cmd_len,
   output logic [DATA_W-1:0] cmd_wdata,
   input  logic              cmd_done,
   output arb_state_t        dbg_state,
   output logic [2:0]        dbg_rd_streak
);

   localparam logic [2:0]       STREAK_MAX = 3'(STARVE_MAX);
   localparam logic [LEN_W-1:0] LEN_RD     = LEN_W'(RD_LEN);
   localparam logic [LEN_W-1:0] LEN_WR     = LEN_W'(1);

   arb_state_t        state_q, state_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [2:0]        streak_q, streak_d;
   logic              wr_ack_q;
   logic              wr_pend, grant_wr, grant_rd, handshake;

   // Handshake: cmd_valid rises the cycle after a grant and the payload is frozen
   // until the cycle cmd_valid & cmd_ready are both high; that cycle is the accept.
   always_comb begin
      state_d   = state_q;
      op_d      = CMD_NONE;
      addr_d    = '0;
      len_d     = '0;
      wdata_d   = '0;
      streak_d  = streak_q;
      wr_pend   = wr_full & ~wr_ack_q;
      grant_wr  = ~ref_req & wr_pend & (~rd_req | (streak_q == STREAK_MAX));
      grant_rd  = ~ref_req & rd_req & ~grant_wr;
      handshake = (state_q == ST_ISSUE) & cmd_ready;
      cmd_valid = (state_q == ST_ISSUE);
      ref_ack   = handshake & (op_q == CMD_REF);
      rd_ack    = handshake & (op_q == CMD_READ);
      rd_done   = (state_q == ST_BUSY) & cmd_done & (op_q == CMD_READ);

      if (ref_req) begin
         op_d = CMD_REF;
      end else if (grant_rd) begin
         op_d   = CMD_READ;
         addr_d = pack_addr(rd_page, rd_row, '0);
         len_d  = LEN_RD;
      end else if (grant_wr) begin
         op_d    = CMD_WRITE;
         addr_d  = pack_addr(wr_page, wr_row, wr_col);
         len_d   = LEN_WR;
         wdata_d = wr_data;
      end

      case (state_q)
         ST_IDLE: begin
            if (ref_req | rd_req | wr_pend) state_d = ST_ISSUE;
            // Streak only counts reads that actually delay a waiting write.
            if (grant_wr || !wr_pend)
               streak_d = '0;
            else if (grant_rd && streak_q != STREAK_MAX)
               streak_d = streak_q + 3'd1;
         end
         ST_ISSUE: if (cmd_ready) state_d = ST_BUSY;
         ST_BUSY:  if (cmd_done)  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         state_q  <= ST_IDLE;
         op_q     <= CMD_NONE;
         addr_q   <= '0;
         len_q    <= '0;
         wdata_q  <= '0;
         streak_q <= '0;
         wr_ack_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         if (state_q == ST_IDLE && state_d == ST_ISSUE) begin
            op_q    <= op_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
         end
         // Held until the FIFO shows empty so the stale word is never granted twice.
         if (handshake && op_q == CMD_WRITE)
            wr_ack_q <= 1'b1;
         else if (!wr_full)
            wr_ack_q <= 1'b0;
      end
   end

   assign wr_ack        = wr_ack_q;
   assign cmd_op        = op_q;
   assign cmd_addr      = addr_q;
   assign cmd_len       = len_q;
   assign cmd_wdata     = wdata_q;
   assign dbg_state     = state_q;
   assign dbg_rd_streak = streak_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: priority, ISSUE hold, read starvation
// limit, write/read address packing and reset out of BUSY.
module tb_sdram_port_arbiter;
   import sdram_port_arbiter_pkg::*;

   logic              clk = 1'b0;
   logic              sclr;
   logic              ref_req, ref_ack;
   logic              rd_req, rd_ack, rd_done;
   logic [2:0]        rd_page;
   logic [8:0]        rd_row;
   logic              wr_full, wr_ack;
   logic [15:0]       wr_data;
   logic [2:0]        wr_page;
   logic [8:0]        wr_row;
   logic [9:0]        wr_col;
   logic              cmd_valid, cmd_ready, cmd_done;
   logic [1:0]        cmd_op;
   logic [21:0]       cmd_addr;
   logic [9:0]        cmd_len;
   logic [15:0]       cmd_wdata;
   arb_state_t        dbg_state;
   logic [2:0]        dbg_rd_streak;

   int errors = 0;
   int checks = 0;
   logic [23:0] exp_q[$];

   sdram_port_arbiter #(.RD_LEN(800), .STARVE_MAX(4), .LEN_W(10)) dut (
      .clk(clk), .sclr(sclr),
      .ref_req(ref_req), .ref_ack(ref_ack),
      .rd_req(rd_req), .rd_page(rd_page), .rd_row(rd_row),
      .rd_ack(rd_ack), .rd_done(rd_done),
      .wr_full(wr_full), .wr_data(wr_data), .wr_page(wr_page),
      .wr_row(wr_row), .wr_col(wr_col), .wr_ack(wr_ack),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
      .cmd_done(cmd_done), .dbg_state(dbg_state), .dbg_rd_streak(dbg_rd_streak)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Controller driver: takes the next expected {op,addr}, holds ready low for
   // 'hold' cycles, accepts, then completes the command two cycles later.
   task automatic serve(input logic [9:0] exp_len, input logic [15:0] exp_wdata,
                        input int hold, input bit drop_rd);
      logic [23:0] ent;
      logic [1:0]  eop;
      int n;
      ent = exp_q.pop_front();
      eop = ent[23:22];
      n = 0;
      while (cmd_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("cmd_valid_wait", {31'd0, cmd_valid}, 1);
      if (cmd_valid !== 1'b1) return;
      check("cmd_op", {30'd0, cmd_op}, {30'd0, eop});
      check("cmd_addr", {10'd0, cmd_addr}, {10'd0, ent[21:0]});
      check("cmd_len", {22'd0, cmd_len}, {22'd0, exp_len});
      check("cmd_wdata", {16'd0, cmd_wdata}, {16'd0, exp_wdata});
      for (int i = 0; i < hold; i++) begin
         cmd_ready = 1'b0;
         #1;
         check("hold_valid", {31'd0, cmd_valid}, 1);
         check("hold_op", {30'd0, cmd_op}, {30'd0, eop});
         check("hold_addr", {10'd0, cmd_addr}, {10'd0, ent[21:0]});
         check("hold_no_ack", {30'd0, ref_ack, rd_ack}, 0);
         tick();
      end
      cmd_ready = 1'b1;
      #1;
      check("ref_ack", {31'd0, ref_ack}, {31'd0, eop == CMD_REF});
      check("rd_ack", {31'd0, rd_ack}, {31'd0, eop == CMD_READ});
      tick();
      cmd_ready = 1'b0;
      if (eop == CMD_REF) ref_req = 1'b0;
      if (eop == CMD_READ && drop_rd) rd_req = 1'b0;
      #1;
      check("busy_valid", {31'd0, cmd_valid}, 0);
      check("busy_ack_pulse", {30'd0, ref_ack, rd_ack}, 0);
      check("wr_ack_set", {31'd0, wr_ack}, {31'd0, eop == CMD_WRITE});
      tick();
      tick();
      cmd_done = 1'b1;
      #1;
      check("rd_done", {31'd0, rd_done}, {31'd0, eop == CMD_READ});
      tick();
      cmd_done = 1'b0;
      #1;
      check("back_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
   endtask

   initial begin
      int n;
      sclr = 1'b1; ref_req = 1'b0; rd_req = 1'b0; rd_page = '0; rd_row = '0;
      wr_full = 1'b0; wr_data = '0; wr_page = '0; wr_row = '0; wr_col = '0;
      cmd_ready = 1'b0; cmd_done = 1'b0;
      tick(); tick();

      // reset state
      check("rst_valid", {31'd0, cmd_valid}, 0);
      check("rst_op_addr", {8'd0, cmd_op, cmd_addr}, 0);
      check("rst_len_wdata", {6'd0, cmd_len, cmd_wdata}, 0);
      check("rst_acks", {28'd0, ref_ack, rd_ack, rd_done, wr_ack}, 0);
      check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      check("rst_streak", {29'd0, dbg_rd_streak}, 0);
      sclr = 1'b0;
      tick();

      // all three requests at once: REFRESH (held 5 cycles), READ, WRITE
      ref_req = 1'b1; rd_req = 1'b1; rd_page = 3'd1; rd_row = 9'd479;
      wr_full = 1'b1; wr_data = 16'hF800; wr_page = 3'd2; wr_row = 9'd5; wr_col = 10'd7;
      exp_q.push_back({CMD_REF,   22'h000000});
      exp_q.push_back({CMD_READ,  22'h0F7C00});
      exp_q.push_back({CMD_WRITE, 22'h101407});
      serve(10'd0, 16'h0000, 5, 1'b0);
      check("streak_after_ref", {29'd0, dbg_rd_streak}, 0);
      serve(10'd800, 16'h0000, 0, 1'b1);
      check("streak_after_rd", {29'd0, dbg_rd_streak}, 1);
      serve(10'd1, 16'hF800, 0, 1'b0);
      check("streak_after_wr", {29'd0, dbg_rd_streak}, 0);

      // stale FIFO word is not re-granted while wr_ack is high
      for (int i = 0; i < 3; i++) begin
         tick();
         check("no_second_write", {31'd0, cmd_valid}, 0);
         check("wr_ack_held", {31'd0, wr_ack}, 1);
      end
      wr_full = 1'b0;
      tick();
      check("wr_ack_clear", {31'd0, wr_ack}, 0);
      check("idle_after_wr", {30'd0, dbg_state}, {30'd0, ST_IDLE});

      // continuous reads with a pending write: 4 READs then the WRITE
      rd_req = 1'b1; rd_page = 3'd3; rd_row = 9'd10;
      wr_full = 1'b1; wr_data = 16'hA5A5; wr_page = 3'd7; wr_row = 9'd511; wr_col = 10'd1023;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({CMD_READ, 22'h182800});
         serve(10'd800, 16'h0000, 0, 1'b0);
         check("streak_count", {29'd0, dbg_rd_streak}, i + 1);
      end
      exp_q.push_back({CMD_WRITE, 22'h3FFFFF});
      serve(10'd1, 16'hA5A5, 0, 1'b0);
      rd_req = 1'b0;
      check("streak_cleared", {29'd0, dbg_rd_streak}, 0);
      wr_full = 1'b0;
      tick(); tick();
      check("wr_ack_clear2", {31'd0, wr_ack}, 0);
      check("idle_quiet", {31'd0, cmd_valid}, 0);

      // sclr while BUSY, then a stray cmd_done
      rd_req = 1'b1; rd_page = 3'd5; rd_row = 9'd0;
      n = 0;
      while (cmd_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("sclr_valid_wait", {31'd0, cmd_valid}, 1);
      cmd_ready = 1'b1;
      #1;
      check("sclr_rd_ack", {31'd0, rd_ack}, 1);
      tick();
      cmd_ready = 1'b0; rd_req = 1'b0;
      check("sclr_in_busy", {30'd0, dbg_state}, {30'd0, ST_BUSY});
      sclr = 1'b1;
      tick();
      sclr = 1'b0;
      #1;
      check("sclr_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      check("sclr_op_addr", {8'd0, cmd_op, cmd_addr}, 0);
      check("sclr_len_wdata", {6'd0, cmd_len, cmd_wdata}, 0);
      check("sclr_ctrl", {27'd0, cmd_valid, ref_ack, rd_ack, rd_done, wr_ack}, 0);
      cmd_done = 1'b1;
      #1;
      check("stray_done_rd_done", {31'd0, rd_done}, 0);
      tick();
      cmd_done = 1'b0;
      #1;
      check("stray_done_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      check("stray_done_valid", {31'd0, cmd_valid}, 0);
      check("exp_q_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
